// File: rtl/write_resp_router_pkg.sv
// Shared constants and types for the write-response router.
package write_resp_router_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_DRIVE  = 2'd2
    } resp_state_e;

endpackage

// File: rtl/write_resp_router_orphan_watchdog.sv
// Counts consecutive cycles of a slave response with no queue owner and
// raises a sticky flag once the run length reaches the limit.
module resp_orphan_watchdog #(
    parameter int Orphan_Limit = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    output logic orphan_err
);

    localparam int CW = $clog2(Orphan_Limit + 1);
    localparam logic [CW-1:0] LIMIT = CW'(Orphan_Limit);

    logic [CW-1:0] cnt;

    // Run-length counter, clears on any break, holds once the limit is hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!stall) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Sticky flag sets on the edge where the count reaches the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            orphan_err <= 1'b0;
        end else if (stall && (cnt >= LIMIT - 1'b1)) begin
            orphan_err <= 1'b1;
        end
    end

endmodule

// File: rtl/write_resp_router.sv
// Routes one slave B response to the master named at the head of the
// write-response ordering queue, and pops the queue on master handshake.
module write_resp_router
    import write_resp_router_pkg::*;
#(
    parameter int Masters_Num  = 2,
    parameter int ID_Size      = $clog2(Masters_Num),
    parameter int Orphan_Limit = 16,
    parameter int Cnt_Width    = 8
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic [ID_Size-1:0]         Resp_Master_ID,
    input  logic                       Resp_Master_Valid,
    output logic                       Write_Resp_Finsh,
    input  logic                       S_BVALID,
    input  logic [1:0]                 S_BRESP,
    output logic                       S_BREADY,
    output logic [Masters_Num-1:0]     M_BVALID,
    output logic [2*Masters_Num-1:0]   M_BRESP,
    input  logic [Masters_Num-1:0]     M_BREADY,
    output logic                       Resp_Error,
    output logic [Cnt_Width-1:0]       Err_Count
);

    resp_state_e                state, state_nxt;
    logic [ID_Size-1:0]         cur_id;
    logic [1:0]                 cur_resp;
    logic                       id_ok;
    logic                       m_hs;
    logic [Masters_Num-1:0]     bvalid_load;
    logic [2*Masters_Num-1:0]   bresp_load;
    logic                       range_err;
    logic                       orphan_err;
    logic                       orphan_stall;

    assign id_ok = (int'(cur_id) < Masters_Num);

    // A real master handshake; an unroutable ID pops without one.
    assign m_hs = (state == ST_DRIVE) && id_ok && M_BREADY[cur_id];

    // State register.
    always_ff @(posedge ACLK) begin
        if (ARESET) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state, slave ready and queue pop strobe.
    always_comb begin
        state_nxt        = state;
        S_BREADY         = 1'b0;
        Write_Resp_Finsh = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Resp_Master_Valid) state_nxt = ST_ACCEPT;
            end
            ST_ACCEPT: begin
                S_BREADY = 1'b1;
                if (S_BVALID) state_nxt = ST_DRIVE;
            end
            ST_DRIVE: begin
                Write_Resp_Finsh = !id_ok || M_BREADY[cur_id];
                if (Write_Resp_Finsh) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // One-hot valid and sliced response for the latched owner.
    always_comb begin
        bvalid_load = '0;
        bresp_load  = '0;
        for (int i = 0; i < Masters_Num; i++) begin
            bvalid_load[i]      = id_ok && (int'(cur_id) == i);
            bresp_load[2*i +: 2] = bvalid_load[i] ? S_BRESP : OKAY;
        end
    end

    // Owner/response latches and registered master B outputs.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cur_id   <= '0;
            cur_resp <= OKAY;
            M_BVALID <= '0;
            M_BRESP  <= '0;
        end else begin
            if (state == ST_IDLE && Resp_Master_Valid) cur_id <= Resp_Master_ID;
            if (state == ST_ACCEPT && S_BVALID) begin
                cur_resp <= S_BRESP;
                M_BVALID <= bvalid_load;
                M_BRESP  <= bresp_load;
            end else if (Write_Resp_Finsh) begin
                M_BVALID <= '0;
                M_BRESP  <= '0;
            end
        end
    end

    // Sticky out-of-range flag and saturating non-OKAY delivery count.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            range_err <= 1'b0;
            Err_Count <= '0;
        end else begin
            if (state == ST_DRIVE && !id_ok) range_err <= 1'b1;
            if (m_hs && cur_resp != OKAY && Err_Count != '1) Err_Count <= Err_Count + 1'b1;
        end
    end

    // Slave is stalled with a response but the queue has no owner for it.
    assign orphan_stall = (state == ST_IDLE) && S_BVALID && !Resp_Master_Valid;

    resp_orphan_watchdog #(
        .Orphan_Limit(Orphan_Limit)
    ) u_watchdog (
        .clk        (ACLK),
        .rst        (ARESET),
        .stall      (orphan_stall),
        .orphan_err (orphan_err)
    );

    assign Resp_Error = range_err | orphan_err;

endmodule
